// File: rtl/alu_pkg.sv
// Shared encodings for the alu_mdu execute unit: opcodes, FSM states and
// iterative-datapath mode select.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SLL   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SRA   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULHU = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU deliver the upper accumulator half, the others the lower.
  function automatic logic takes_hi(input logic [3:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply or restoring divide,
// built around a single (XLEN+1)-bit adder/subtractor.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi
);

  localparam int SHW = $clog2(XLEN);

  logic            run_q, run_d;
  logic            mode_q, mode_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] opd_q, opd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN:0]   add_x, add_y, add_s;
  logic [XLEN-1:0] step_hi, step_lo;

  // Divide subtracts via inverted operand plus carry-in, so one adder serves both modes.
  always_comb begin
    add_x = (mode_q == MODE_DIV) ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    add_y = (mode_q == MODE_DIV) ? ~{1'b0, opd_q} : {1'b0, opd_q};
    add_s = add_x + add_y + {{XLEN{1'b0}}, mode_q};
    step_hi = hi_q;
    step_lo = lo_q;
    if (mode_q == MODE_DIV) begin
      if (!add_s[XLEN]) begin
        step_hi = add_s[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = add_x[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = lo_q[0] ? {add_s, lo_q[XLEN-1:1]}
                                   : {1'b0, hi_q, lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    run_d  = run_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    opd_d  = opd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start) begin
      run_d  = 1'b1;
      mode_d = mode;
      cnt_d  = SHW'(XLEN - 1);
      opd_d  = (mode == MODE_DIV) ? b : a;
      hi_d   = '0;
      lo_d   = (mode == MODE_DIV) ? a : b;
    end else if (run_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) run_d = 1'b0;
    end
  end

  // done flags the final step; lo/hi carry that step's result so the caller can register it now.
  assign done = run_q && (cnt_q == '0);
  assign lo   = step_lo;
  assign hi   = step_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      opd_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      run_q  <= run_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      opd_q  <= opd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: single-cycle ALU plus iterative unsigned MUL/DIV,
// with valid/ready handshakes on both the operand and the result side.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] q,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  logic [1:0]             state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [XLEN-1:0]        q_q, q_d;
  logic [XLEN-1:0]        alu_res;
  logic signed [XLEN-1:0] a_s;
  logic [SHW-1:0]         shamt;
  logic                   accept;
  logic                   iter_start, iter_mode, iter_done;
  logic [XLEN-1:0]        iter_lo, iter_hi;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);
  assign q         = q_q;
  assign a_s       = a;
  assign shamt     = b[SHW-1:0];
  assign iter_mode = is_div(op) ? MODE_DIV : MODE_MUL;

  always_comb begin
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SLL:  alu_res = a << shamt;
      OP_SUB:  alu_res = a - b;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      default: alu_res = '0;
    endcase
  end

  // A new accept overrides the DONE/IDLE transition, giving back-to-back issue.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    q_d        = q_q;
    iter_start = 1'b0;
    case (state_q)
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          state_d = ST_DONE;
          q_d     = takes_hi(op_q) ? iter_hi : iter_lo;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      op_d = op;
      if (is_mul(op)) begin
        state_d    = ST_MUL;
        iter_start = 1'b1;
      end else if (is_div(op) && (b == '0)) begin
        state_d = ST_DONE;
        q_d     = (op == OP_DIVU) ? '1 : a;
      end else if (is_div(op)) begin
        state_d    = ST_DIV;
        iter_start = 1'b1;
      end else begin
        state_d = ST_DONE;
        q_d     = alu_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
    end
  end

  alu_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iter_start),
    .mode  (iter_mode),
    .a     (a),
    .b     (b),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed XLEN=32 scenarios, then a randomized stalled
// op stream on an XLEN=8 instance scored against an arithmetic reference model.
module tb_alu_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [31:0] a, b, q;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, q8;

  int n_chk  = 0;
  int n_pass = 0;

  alu_mdu #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .q(q), .busy(busy)
  );

  alu_mdu #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .q(q8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference result for a w-bit unit, straight from the opcode definitions.
  function automatic longint unsigned ref_op(input int w, input logic [3:0] o,
                                             input longint unsigned x, input longint unsigned y);
    longint unsigned m, r, p;
    longint signed   sx;
    int              sh;
    m  = (64'd1 << w) - 64'd1;
    x  = x & m;
    y  = y & m;
    sh = int'(y % longint'(w));
    sx = ((x >> (w - 1)) & 64'd1) != 0 ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    p  = x * y;
    case (o)
      4'd0:    r = x + y;
      4'd1:    r = x << sh;
      4'd2:    r = x - y;
      4'd3:    r = longint'(sx >>> sh);
      4'd4:    r = x ^ y;
      4'd5:    r = x >> sh;
      4'd6:    r = x | y;
      4'd7:    r = x & y;
      4'd8:    r = p;
      4'd9:    r = p >> w;
      4'd10:   r = (y == 0) ? m : x / y;
      4'd11:   r = (y == 0) ? x : x % y;
      default: r = 0;
    endcase
    return r & m;
  endfunction

  task automatic run32(input string tag, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bad;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, ".in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    bad = 0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".q"}, 64'(q), 64'(exp));
    if (exp_lat > 1) check({tag, ".busy_stall"}, 64'(bad), 64'(0));
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int issued, taken, cyc, seen;
    logic acc_pend;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.out_valid", 64'(out_valid), 64'(0));
    check("reset.q", 64'(q), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.in_ready", 64'(in_ready), 64'(1));

    run32("add",   4'd0,  32'd7,          32'hFFFF_FFFF, 32'd6,          1);
    run32("sra",   4'd3,  32'h8000_0000,  32'd31,        32'hFFFF_FFFF,  1);
    run32("sll33", 4'd1,  32'h4000_0001,  32'd33,        32'h8000_0002,  1);
    run32("sub",   4'd2,  32'd3,          32'd5,         32'hFFFF_FFFE,  1);
    run32("srl",   4'd5,  32'h8000_0000,  32'd4,         32'h0800_0000,  1);
    run32("mulhu", 4'd9,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE,  33);
    run32("mul",   4'd8,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001,  33);
    run32("divu",  4'd10, 32'd100,        32'd7,         32'd14,         33);
    run32("remu",  4'd11, 32'd100,        32'd7,         32'd2,          33);
    run32("div0",  4'd10, 32'd12345,      32'd0,         32'hFFFF_FFFF,  1);
    run32("rem0",  4'd11, 32'd5,          32'd0,         32'd5,          1);
    run32("rsvd",  4'd13, 32'd5,          32'd6,         32'd0,          1);

    // Backpressure, then release with a new op on the same edge.
    @(negedge clk);
    op = 4'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.q", 64'(q), 64'(3));
      check("bp.out_valid", 64'(out_valid), 64'(1));
      check("bp.in_ready", 64'(in_ready), 64'(0));
      @(negedge clk);
    end
    op = 4'd4; a = 32'h0000_00F0; b = 32'h0000_00FF; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b.out_valid", 64'(out_valid), 64'(1));
    check("b2b.q", 64'(q), 64'(32'h0000_000F));

    // Reset in the middle of a divide.
    @(negedge clk);
    op = 4'd10; a = 32'd1000; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 64'(out_valid), 64'(0));
    check("rst_mid.busy", 64'(busy), 64'(0));
    check("rst_mid.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_mid.no_result", 64'(seen), 64'(0));
    run32("post_rst_add", 4'd0, 32'd20, 32'd22, 32'd42, 1);

    // Random stalled stream on the 8-bit instance.
    issued = 0; taken = 0; cyc = 0; acc_pend = 1'b0;
    while ((issued < 1000 || exp_q.size() != 0) && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) in_valid8 = 1'b0;
      acc_pend = 1'b0;
      if (!in_valid8 && issued < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid8 = 1'b1;
        op8 = 4'($urandom_range(0, 15));
        a8  = 8'($urandom);
        b8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      out_ready8 = (issued >= 1000) || ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid8 && out_ready8) begin
        if (exp_q.size() == 0) check("rnd.unexpected_result", 64'(exp_q.size()), 64'(1));
        else check($sformatf("rnd.q[%0d]", taken), 64'(q8), 64'(exp_q.pop_front()));
        taken++;
      end
      if (in_valid8 && in_ready8) begin
        exp_q.push_back(8'(ref_op(8, op8, 64'(a8), 64'(b8))));
        issued++;
        acc_pend = 1'b1;
      end
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    out_ready8 = 1'b0;
    check("rnd.taken", 64'(taken), 64'(1000));
    check("rnd.pending", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
